fetch_buffer: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the pipelined RISC-V core, directly upstream of the Decode-stage control and data path. It issues PC-sequential requests to instruction memory, accepts in-order responses with variable latency, and buffers them in a small reservation queue. It presents one instruction per cycle to Decode, honouring Decode stalls and Execute-stage redirects (`i_PCSrcE`).

---
 rtl/fetch_buffer.sv | 171 +++++++++++++++++
 tb/tb_fetch_buffer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction-fetch stage plus IF/ID register.
// Issues PC-sequential fetches, tracks in-order variable-latency responses in a
// small reservation queue, and feeds one instruction per cycle to Decode.
// Optional feature macro: FETCH_BYPASS_EN (response straight into Decode when
// the oldest reserved entry is the one being answered).
module fetch_buffer #(
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input  logic                   i_Clk,
   input  logic                   i_Reset,
   output logic                   o_IMemReqValid,
   input  logic                   i_IMemReqReady,
   output logic [31:0]            o_IMemAddr,
   input  logic                   i_IMemRespValid,
   input  logic [31:0]            i_IMemRespData,
   input  logic                   i_StallD,
   input  logic                   i_PCSrcE,
   input  logic [31:0]            i_PCTargetE,
   output logic [31:0]            o_InstrD,
   output logic [31:0]            o_PCD,
   output logic [31:0]            o_PCPlus4D,
   output logic                   o_ValidD,
   output logic [$clog2(DEPTH):0] o_Count
);

   localparam int              PW        = $clog2(DEPTH);
   localparam int              CW        = PW + 1;
   localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
   localparam logic [CW-1:0]   MAX_OUT_C = CW'(MAX_OUTSTANDING);
   localparam logic [31:0]     NOP       = 32'h0000_0013;

   // fetch PC and queue bookkeeping
   logic [31:0]      r_PC;
   logic [31:0]      r_QPc    [DEPTH];
   logic [31:0]      r_QInstr [DEPTH];
   logic [DEPTH-1:0] r_QFilled;
   logic [PW-1:0]    r_Head;
   logic [PW-1:0]    r_Fill;
   logic [PW-1:0]    r_Tail;
   logic [CW-1:0]    r_Count;
   logic [CW-1:0]    r_Outstanding;
   logic [CW-1:0]    r_Drop;

   // Decode register
   logic [31:0]      r_InstrD;
   logic [31:0]      r_PCD;
   logic             r_ValidD;

   logic             w_ReqValid;
   logic             w_Push;
   logic             w_RespAcc;
   logic             w_RespDrop;
   logic             w_RespFill;
   logic             w_FillWrite;
   logic             w_HeadReady;
   logic             w_Bypass;
   logic             w_Pop;

   // Request gating; reset is folded in so no request is shown while held in reset.
   assign w_ReqValid  = i_Reset & ~i_PCSrcE & (r_Outstanding < MAX_OUT_C) & (r_Count < DEPTH_C);
   assign w_Push      = w_ReqValid & i_IMemReqReady;

   // A response with nothing outstanding is stray and ignored.
   assign w_RespAcc   = i_IMemRespValid & (r_Outstanding != '0);
   assign w_RespDrop  = w_RespAcc & (r_Drop != '0);
   // On a redirect the queue is flushed, so a live response has nowhere to go.
   assign w_RespFill  = w_RespAcc & (r_Drop == '0) & ~i_PCSrcE;

   assign w_HeadReady = (r_Count != '0) & r_QFilled[r_Head];

`ifdef FETCH_BYPASS_EN
   // Head entry is the one being answered right now: hand the word straight to Decode.
   assign w_Bypass    = ~i_PCSrcE & ~i_StallD & ~w_HeadReady & w_RespFill & (r_Fill == r_Head);
`else
   assign w_Bypass    = 1'b0;
`endif

   assign w_Pop       = ~i_PCSrcE & ~i_StallD & (w_HeadReady | w_Bypass);
   assign w_FillWrite = w_RespFill & ~w_Bypass;

   assign o_IMemReqValid = w_ReqValid;
   assign o_IMemAddr     = r_PC;
   assign o_Count        = r_Count;
   assign o_InstrD       = r_InstrD;
   assign o_PCD          = r_PCD;
   assign o_PCPlus4D     = r_PCD + 32'd4;
   assign o_ValidD       = r_ValidD;

   // PC, pointers, occupancy, outstanding and drop counters.
   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         r_PC          <= RESET_PC;
         r_Head        <= '0;
         r_Fill        <= '0;
         r_Tail        <= '0;
         r_Count       <= '0;
         r_Outstanding <= '0;
         r_Drop        <= '0;
      end else begin
         r_Outstanding <= r_Outstanding + CW'(w_Push) - CW'(w_RespAcc);
         if (i_PCSrcE) begin
            r_PC    <= i_PCTargetE;
            r_Head  <= '0;
            r_Fill  <= '0;
            r_Tail  <= '0;
            r_Count <= '0;
            // everything still in flight (minus this cycle's arrival) is stale
            r_Drop  <= r_Outstanding - CW'(w_RespAcc);
         end else begin
            if (w_Push) begin
               r_PC   <= r_PC + 32'd4;
               r_Tail <= r_Tail + PW'(1);
            end
            if (w_RespFill) r_Fill <= r_Fill + PW'(1);
            if (w_Pop)      r_Head <= r_Head + PW'(1);
            r_Count <= r_Count + CW'(w_Push) - CW'(w_Pop);
            if (w_RespDrop) r_Drop <= r_Drop - CW'(1);
         end
      end
   end

   // Per-entry filled flags: cleared on reserve/pop/flush, set when the word lands.
   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         r_QFilled <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_PCSrcE)
               r_QFilled[i] <= 1'b0;
            else if (w_Push && (r_Tail == PW'(i)))
               r_QFilled[i] <= 1'b0;
            else if (w_FillWrite && (r_Fill == PW'(i)))
               r_QFilled[i] <= 1'b1;
            else if (w_Pop && (r_Head == PW'(i)))
               r_QFilled[i] <= 1'b0;
         end
      end
   end

   // Queue payload storage; validity is tracked by r_QFilled, so no reset needed.
   always_ff @(posedge i_Clk) begin
      if (w_Push)      r_QPc[r_Tail]    <= r_PC;
      if (w_FillWrite) r_QInstr[r_Fill] <= i_IMemRespData;
   end

   // Decode register: redirect bubble, stall hold, load head (or bypass), else bubble.
   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         r_ValidD <= 1'b0;
         r_InstrD <= NOP;
         r_PCD    <= 32'h0000_0000;
      end else if (i_PCSrcE) begin
         r_ValidD <= 1'b0;
      end else if (!i_StallD) begin
         if (w_HeadReady) begin
            r_ValidD <= 1'b1;
            r_InstrD <= r_QInstr[r_Head];
            r_PCD    <= r_QPc[r_Head];
         end else if (w_Bypass) begin
            r_ValidD <= 1'b1;
            r_InstrD <= i_IMemRespData;
            r_PCD    <= r_QPc[r_Head];
         end else begin
            r_ValidD <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed bench for fetch_buffer with an in-order
// fixed-latency instruction memory model.
module tb_fetch_buffer;

   logic        i_Clk = 1'b0;
   logic        i_Reset;
   logic        o_IMemReqValid;
   logic        i_IMemReqReady;
   logic [31:0] o_IMemAddr;
   logic        i_IMemRespValid;
   logic [31:0] i_IMemRespData;
   logic        i_StallD;
   logic        i_PCSrcE;
   logic [31:0] i_PCTargetE;
   logic [31:0] o_InstrD;
   logic [31:0] o_PCD;
   logic [31:0] o_PCPlus4D;
   logic        o_ValidD;
   logic [2:0]  o_Count;

   always #5 i_Clk = ~i_Clk;

   fetch_buffer dut (
      .i_Clk           (i_Clk),
      .i_Reset         (i_Reset),
      .o_IMemReqValid  (o_IMemReqValid),
      .i_IMemReqReady  (i_IMemReqReady),
      .o_IMemAddr      (o_IMemAddr),
      .i_IMemRespValid (i_IMemRespValid),
      .i_IMemRespData  (i_IMemRespData),
      .i_StallD        (i_StallD),
      .i_PCSrcE        (i_PCSrcE),
      .i_PCTargetE     (i_PCTargetE),
      .o_InstrD        (o_InstrD),
      .o_PCD           (o_PCD),
      .o_PCPlus4D      (o_PCPlus4D),
      .o_ValidD        (o_ValidD),
      .o_Count         (o_Count)
   );

   typedef struct packed {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        pend[$];
   int          cyc;
   int          lat;
   int          n_checks;
   int          n_fail;
   logic        last_req_valid;
   logic [31:0] last_addr;

   // memory contents: a fixed function of the address
   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a + 32'h0001_0013;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end else begin
         $display("ok   %s: %h (cycle %0d)", tag, obs, cyc);
      end
   endtask

   // One clock cycle: drive memory response, record handshake, advance.
   task automatic step();
      @(negedge i_Clk);
      i_IMemRespValid = 1'b0;
      i_IMemRespData  = 32'h0;
      if (pend.size() > 0) begin
         if (pend[0].due <= cyc) begin
            i_IMemRespValid = 1'b1;
            i_IMemRespData  = instr_of(pend[0].addr);
            pend.delete(0);
         end
      end
      #1;
      last_req_valid = o_IMemReqValid;
      last_addr      = o_IMemAddr;
      if (o_IMemReqValid && i_IMemReqReady)
         pend.push_back('{addr: o_IMemAddr, due: cyc + lat});
      @(posedge i_Clk);
      cyc++;
      #1;
   endtask

   task automatic wait_valid(input int max_cyc);
      int n;
      n = 0;
      while (!o_ValidD && n < max_cyc) begin
         step();
         n++;
      end
      if (!o_ValidD) check_val("valid_timeout", 32'(o_ValidD), 32'd1);
   endtask

   task automatic check_reset_vals(input string pfx);
      check_val({pfx, "_reqv"},  32'(o_IMemReqValid), 32'd0);
      check_val({pfx, "_addr"},  o_IMemAddr,          32'h0);
      check_val({pfx, "_validd"}, 32'(o_ValidD),      32'd0);
      check_val({pfx, "_instrd"}, o_InstrD,           32'h0000_0013);
      check_val({pfx, "_pcd"},   o_PCD,               32'h0);
      check_val({pfx, "_pcp4"},  o_PCPlus4D,          32'h4);
      check_val({pfx, "_count"}, 32'(o_Count),        32'd0);
   endtask

   // Hold reset two edges, release just after a rising edge.
   task automatic do_reset();
      i_Reset         = 1'b0;
      i_IMemReqReady  = 1'b1;
      i_IMemRespValid = 1'b0;
      i_IMemRespData  = 32'h0;
      i_StallD        = 1'b0;
      i_PCSrcE        = 1'b0;
      i_PCTargetE     = 32'h0;
      pend.delete();
      repeat (2) @(posedge i_Clk);
      #1;
      i_Reset = 1'b1;
      cyc     = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_pc;
      logic        prev_hold;
      logic [31:0] prev_addr;
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      lat      = 1;
      i_Reset         = 1'b0;
      i_IMemReqReady  = 1'b1;
      i_IMemRespValid = 1'b0;
      i_IMemRespData  = 32'h0;
      i_StallD        = 1'b0;
      i_PCSrcE        = 1'b0;
      i_PCTargetE     = 32'h0;

      // reset values while reset is held
      repeat (2) @(posedge i_Clk);
      #1;
      check_reset_vals("rst");
      i_Reset = 1'b1;
      cyc     = 0;

      // sequential stream, L=1
      step();
      check_val("t1_first_reqv", 32'(last_req_valid), 32'd1);
      check_val("t1_first_addr", last_addr, 32'h0);
      check_val("t1_c0_validd", 32'(o_ValidD), 32'd0);
      step();
      check_val("t1_c1_validd", 32'(o_ValidD), 32'd0);
      step();
      check_val("t1_c2_validd", 32'(o_ValidD), 32'd1);
      check_val("t1_c2_pcd", o_PCD, 32'h0);
      check_val("t1_c2_pcp4", o_PCPlus4D, 32'h4);
      check_val("t1_c2_instr", o_InstrD, 32'h0001_0013);
      step();
      check_val("t1_c3_pcd", o_PCD, 32'h4);
      check_val("t1_c3_pcp4", o_PCPlus4D, 32'h8);
      step();
      check_val("t1_c4_pcd", o_PCD, 32'h8);
      check_val("t1_c4_pcp4", o_PCPlus4D, 32'hC);
      check_val("t1_c4_count", 32'(o_Count), 32'd2);

      // stall 5 cycles: queue saturates, D held
      i_StallD = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check_val("t2_stall_pcd", o_PCD, 32'h8);
         check_val("t2_stall_validd", 32'(o_ValidD), 32'd1);
         if (k >= 1) begin
            check_val("t2_full_count", 32'(o_Count), 32'd4);
            check_val("t2_full_reqv", 32'(o_IMemReqValid), 32'd0);
         end
      end
      i_StallD = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         check_val("t2_drain_validd", 32'(o_ValidD), 32'd1);
         check_val("t2_drain_pcd", o_PCD, 32'hC + 32'(4 * k));
      end

      // redirect with D valid; the response arriving this cycle is discarded
      i_PCSrcE    = 1'b1;
      i_PCTargetE = 32'h300;
      step();
      check_val("t3a_redir_reqv", 32'(last_req_valid), 32'd0);
      check_val("t3a_bubble", 32'(o_ValidD), 32'd0);
      i_PCSrcE = 1'b0;
      step();
      check_val("t3a_tgt_reqv", 32'(last_req_valid), 32'd1);
      check_val("t3a_tgt_addr", last_addr, 32'h300);
      wait_valid(20);
      check_val("t3a_first_pcd", o_PCD, 32'h300);
      check_val("t3a_first_instr", o_InstrD, 32'h0001_0313);

      // redirect to 0x100 with 2 outstanding, L=4
      do_reset();
      lat = 4;
      step();
      step();
      check_val("t3b_second_req", 32'(last_req_valid), 32'd1);
      i_PCSrcE    = 1'b1;
      i_PCTargetE = 32'h100;
      step();
      check_val("t3b_redir_reqv", 32'(last_req_valid), 32'd0);
      check_val("t3b_bubble", 32'(o_ValidD), 32'd0);
      i_PCSrcE = 1'b0;
      wait_valid(40);
      check_val("t3b_first_pcd", o_PCD, 32'h100);
      check_val("t3b_first_instr", o_InstrD, 32'h0001_0113);

      // redirect in the same cycle as a response, L=2
      do_reset();
      lat = 2;
      step();
      step();
      i_PCSrcE    = 1'b1;
      i_PCTargetE = 32'h200;
      step();
      check_val("t4_redir_resp_seen", 32'(i_IMemRespValid), 32'd1);
      i_PCSrcE = 1'b0;
      step();
      check_val("t4_tgt_reqv", 32'(last_req_valid), 32'd1);
      check_val("t4_tgt_addr", last_addr, 32'h200);
      wait_valid(30);
      check_val("t4_first_pcd", o_PCD, 32'h200);
      check_val("t4_first_instr", o_InstrD, 32'h0001_0213);

      // ready toggling 1/0, L=1: held address, no duplicate/skipped PCs
      do_reset();
      lat       = 1;
      exp_pc    = 32'h0;
      prev_hold = 1'b0;
      prev_addr = 32'h0;
      for (int k = 0; k < 30; k++) begin
         i_IMemReqReady = (k % 2 == 0);
         step();
         if (prev_hold) check_val("t5_addr_held", last_addr, prev_addr);
         prev_hold = last_req_valid & ~i_IMemReqReady;
         prev_addr = last_addr;
         if (o_ValidD) begin
            check_val("t5_seq_pcd", o_PCD, exp_pc);
            exp_pc = exp_pc + 32'd4;
         end
      end
      check_val("t5_progress", 32'(exp_pc >= 32'h20), 32'd1);

      // asynchronous reset mid-stream, L=3
      i_IMemReqReady = 1'b1;
      lat = 3;
      repeat (8) step();
      #2;
      i_Reset = 1'b0;
      #1;
      check_reset_vals("t6_async");
      pend.delete();
      i_IMemRespValid = 1'b0;
      repeat (2) @(posedge i_Clk);
      #1;
      i_Reset = 1'b1;
      cyc = 0;
      lat = 1;
      step();
      check_val("t6_restart_reqv", 32'(last_req_valid), 32'd1);
      check_val("t6_restart_addr", last_addr, 32'h0);
      wait_valid(20);
      check_val("t6_first_pcd", o_PCD, 32'h0);
      step();
      check_val("t6_second_pcd", o_PCD, 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
